// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer
//   Walks the OV7670 register-init ROM from address 0 and turns every 16-bit
//   entry {reg, val} into one SCCB write request for the downstream SCCB
//   master. Two entries are special:
//     16'hFFF0  wait DELAY_CYCLES clock cycles, issue nothing
//     16'hFFFF  end of table, go to DONE
//   A write of COM7 (reg 8'h12) with val[7]=1 soft-resets the sensor, so an
//   extra RESET_SETTLE cycles are waited after its completion. A table with
//   no end marker still terminates after address 8'hFF (no wrap).
//
// Ports
//   clk_i         clock, all logic on posedge
//   rst_i         synchronous active-high reset, aborts any sequence
//   start_i       1-cycle pulse, starts/restarts from IDLE or DONE only
//   rom_addr_o    ROM read address (registered ROM, 1-cycle latency)
//   rom_data_i    ROM read data {reg[15:8], val[7:0]}
//   sccb_valid_o  write request valid
//   sccb_ready_i  SCCB master can accept
//   sccb_reg_o    register address of the request
//   sccb_data_o   register value of the request
//   sccb_done_i   1-cycle pulse: accepted transaction finished
//   busy_o        high in every state except IDLE and DONE
//   done_o        high while in DONE
//   state_o       current FSM state (debug)
//
// Handshake: a request is transferred on the posedge where sccb_valid_o and
// sccb_ready_i are both high; until then valid, reg and data stay constant.
// The transaction is complete on the first sccb_done_i pulse after that edge.

module ov7670_config_sequencer #(
  parameter int DELAY_CYCLES = 1_000_000,
  parameter int RESET_SETTLE = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [7:0]  rom_addr_o,
  input  logic [15:0] rom_data_i,
  output logic        sccb_valid_o,
  input  logic        sccb_ready_i,
  output logic [7:0]  sccb_reg_o,
  output logic [7:0]  sccb_data_o,
  input  logic        sccb_done_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [2:0]  state_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_REQ       = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_DELAY     = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;
  localparam logic [15:0] ENTRY_END   = 16'hFFFF;
  localparam logic [7:0]  REG_COM7    = 8'h12;

  logic [2:0]  state;
  logic [2:0]  state_n;
  logic [31:0] cnt;
  logic        last_addr;
  logic        com7_reset;

  assign state_o    = state;
  assign last_addr  = (rom_addr_o == 8'hFF);
  // Payload registers still hold the entry that was just written.
  assign com7_reset = (sccb_reg_o == REG_COM7) && sccb_data_o[7];

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: if (start_i) state_n = S_FETCH;
      S_FETCH:        state_n = S_DECODE;
      S_DECODE: begin
        if (rom_data_i == ENTRY_END)        state_n = S_DONE;
        else if (rom_data_i == ENTRY_DELAY) state_n = S_DELAY;
        else                                state_n = S_REQ;
      end
      S_REQ:          if (sccb_ready_i) state_n = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (sccb_done_i) begin
          if (com7_reset)     state_n = S_DELAY;
          else if (last_addr) state_n = S_DONE;
          else                state_n = S_FETCH;
        end
      end
      S_DELAY: begin
        if (cnt == '0) state_n = last_addr ? S_DONE : S_FETCH;
      end
      default:        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      rom_addr_o   <= '0;
      sccb_valid_o <= 1'b0;
      sccb_reg_o   <= '0;
      sccb_data_o  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      cnt          <= '0;
    end else begin
      state  <= state_n;
      // Status flags follow the next state so they line up with state.
      busy_o <= (state_n != S_IDLE) && (state_n != S_DONE);
      done_o <= (state_n == S_DONE);

      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) rom_addr_o <= '0;
        end
        S_DECODE: begin
          if (rom_data_i == ENTRY_DELAY) begin
            cnt <= 32'(DELAY_CYCLES - 1);
          end else if (rom_data_i != ENTRY_END) begin
            sccb_reg_o   <= rom_data_i[15:8];
            sccb_data_o  <= rom_data_i[7:0];
            sccb_valid_o <= 1'b1;
          end
        end
        S_REQ: begin
          if (sccb_ready_i) sccb_valid_o <= 1'b0;
        end
        S_WAIT_DONE: begin
          if (sccb_done_i) begin
            if (com7_reset)      cnt <= 32'(RESET_SETTLE - 1);
            else if (!last_addr) rom_addr_o <= rom_addr_o + 8'd1;
          end
        end
        S_DELAY: begin
          if (cnt == '0) begin
            if (!last_addr) rom_addr_o <= rom_addr_o + 8'd1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Directed bench for ov7670_config_sequencer with a registered ROM model and
// a simple SCCB responder (done pulse DONE_LAT cycles after acceptance).
module tb_ov7670_config_sequencer;

  localparam int DONE_LAT = 5;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sccb_valid;
  logic        sccb_ready;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_data;
  logic        sccb_done;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  ov7670_config_sequencer #(
    .DELAY_CYCLES(16),
    .RESET_SETTLE(8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .sccb_valid_o (sccb_valid),
    .sccb_ready_i (sccb_ready),
    .sccb_reg_o   (sccb_reg),
    .sccb_data_o  (sccb_data),
    .sccb_done_i  (sccb_done),
    .busy_o       (busy),
    .done_o       (done),
    .state_o      (state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- ROM model ----------------
  logic [15:0] rom_mem [256];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic rom_fill_end();
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
  endtask

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: {rom_addr, reg, data} expected at each accepted request.
  logic [23:0] exp_q[$];
  int acc_count = 0;

  // ---------------- SCCB responder ----------------
  logic resp_en    = 1'b1;
  logic stray_req  = 1'b0;
  logic acc_seen   = 1'b0;
  int   done_cnt   = 0;
  int   last_done_cyc = 0;
  logic gap_armed  = 1'b0;
  int   gap_meas   = -1;

  initial begin
    sccb_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sccb_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          sccb_done     = 1'b1;
          last_done_cyc = cyc + 1;
          gap_armed     = 1'b1;
        end
      end
      if (acc_seen && resp_en) done_cnt = DONE_LAT - 1;
      if (stray_req) begin
        sccb_done = 1'b1;
        stray_req = 1'b0;
      end
    end
  end

  // ---------------- monitor (negedge) ----------------
  int first_valid_cyc = -1;
  int excl_bad = 0;
  int addr_bad = 0;
  logic [7:0] prev_addr = 8'h00;

  always @(negedge clk) begin
    acc_seen = sccb_valid && sccb_ready;
    if (acc_seen) begin
      acc_count++;
      check("req_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("req_payload", {8'h00, rom_addr, sccb_reg, sccb_data}, {8'h00, exp_q.pop_front()});
    end
    if (sccb_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (state == ST_FETCH && gap_armed && gap_meas < 0) gap_meas = cyc - last_done_cyc;
    if (state == ST_FETCH) gap_armed = 1'b0;
    if (busy && done) excl_bad++;
    if (rom_addr != prev_addr && state != ST_FETCH && state != ST_IDLE) addr_bad++;
    prev_addr = rom_addr;
  end

  // ---------------- driver tasks ----------------
  int start_cyc = 0;

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int n = 0;
    while (state != st && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, {29'd0, state}, {29'd0, st});
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    sccb_ready = 1'b1;
    rom_fill_end();

    // Reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", {busy, done, sccb_valid, rom_addr, sccb_reg, sccb_data}, 32'd0);
    check("rst_state", {29'd0, state}, {29'd0, ST_IDLE});
    idle_cycles(100);
    check("no_start_reqs", 32'(acc_count), 32'd0);
    check("no_start_busy", {31'd0, busy}, 32'd0);

    // Delay marker + COM7 reset settle
    rom_fill_end();
    rom_mem[0] = 16'hFFF0;
    rom_mem[1] = 16'h1280;
    rom_mem[2] = 16'h1204;
    rom_mem[3] = 16'hFFFF;
    acc_count       = 0;
    first_valid_cyc = -1;
    gap_meas        = -1;
    exp_q.push_back({8'h01, 8'h12, 8'h80});
    exp_q.push_back({8'h02, 8'h12, 8'h04});
    pulse_start();
    wait_done("seq1_done", 300);
    check("seq1_reqs", 32'(acc_count), 32'd2);
    check("seq1_first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd21);
    check("seq1_first_valid_ge16", 32'(first_valid_cyc - start_cyc >= 16), 32'd1);
    check("seq1_settle_gap", 32'(gap_meas), 32'd8);
    check("seq1_not_busy", {31'd0, busy}, 32'd0);

    // Backpressure
    rom_fill_end();
    rom_mem[0] = 16'h3355;
    acc_count  = 0;
    sccb_ready = 1'b0;
    exp_q.push_back({8'h00, 8'h33, 8'h55});
    pulse_start();
    wait_state("bp_req", ST_REQ, 50);
    begin
      int stable_bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!(sccb_valid && sccb_reg == 8'h33 && sccb_data == 8'h55 && state == ST_REQ)) stable_bad++;
      end
      check("bp_held_stable", 32'(stable_bad), 32'd0);
    end
    @(posedge clk);
    #1;
    sccb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_accepted_count", 32'(acc_count), 32'd1);
    check("bp_valid_dropped", {31'd0, sccb_valid}, 32'd0);
    wait_done("bp_done", 100);

    // Full table, no end marker
    for (int i = 0; i < 256; i++) begin
      rom_mem[i] = {8'h20, 8'(i)};
      exp_q.push_back({8'(i), 8'h20, 8'(i)});
    end
    acc_count = 0;
    pulse_start();
    wait_done("full_done", 4000);
    check("full_reqs", 32'(acc_count), 32'd256);
    check("full_last_addr", {24'd0, rom_addr}, 32'h000000FF);
    idle_cycles(20);
    check("full_no_wrap", 32'(acc_count), 32'd256);

    // Reset during WAIT_DONE, stray done afterwards
    rom_fill_end();
    rom_mem[0] = 16'h1111;
    rom_mem[1] = 16'h2222;
    acc_count = 0;
    resp_en   = 1'b0;
    exp_q.push_back({8'h00, 8'h11, 8'h11});
    pulse_start();
    wait_state("abort_wait_done", ST_WAIT_DONE, 50);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", {busy, done, sccb_valid, rom_addr, sccb_reg, sccb_data}, 32'd0);
    stray_req = 1'b1;
    idle_cycles(5);
    check("stray_state", {29'd0, state}, {29'd0, ST_IDLE});
    check("stray_reqs", 32'(acc_count), 32'd1);
    resp_en = 1'b1;
    exp_q.push_back({8'h00, 8'h11, 8'h11});
    exp_q.push_back({8'h01, 8'h22, 8'h22});
    pulse_start();
    wait_done("restart_done", 100);
    check("restart_reqs", 32'(acc_count), 32'd3);

    // start while busy ignored, start in DONE re-runs
    acc_count = 0;
    exp_q.push_back({8'h00, 8'h11, 8'h11});
    exp_q.push_back({8'h01, 8'h22, 8'h22});
    pulse_start();
    wait_state("busy_wait_done", ST_WAIT_DONE, 50);
    pulse_start();
    idle_cycles(6);
    pulse_start();
    wait_done("busy_start_done", 100);
    check("busy_start_reqs", 32'(acc_count), 32'd2);
    exp_q.push_back({8'h00, 8'h11, 8'h11});
    exp_q.push_back({8'h01, 8'h22, 8'h22});
    pulse_start();
    wait_done("rerun_done", 100);
    check("rerun_reqs", 32'(acc_count), 32'd4);

    idle_cycles(3);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("busy_done_exclusive", 32'(excl_bad), 32'd0);
    check("addr_stable", 32'(addr_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
